// File: rtl/lpf_frame_scheduler.sv
// Time-shares one low-pass filter between NCH channels, updating all
// outputs once per frame from a snapshot taken at frame_start.
module lpf_frame_scheduler #(
    parameter int NCH     = 2,
    parameter int W       = 11,
    parameter int LPF_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bypass,
    input  logic [NCH*W-1:0] ch_in,
    output logic [W-1:0]     lpf_in,
    input  logic [W-1:0]     lpf_out,
    output logic [NCH*W-1:0] ch_out,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] LAT = 4'(LPF_LAT);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   ch_nxt;
    logic [3:0]      cnt_q, cnt_d;
    logic [W-1:0]    snap_q [NCH];
    logic [W-1:0]    snap_d [NCH];
    logic [W-1:0]    out_q  [NCH];
    logic [W-1:0]    out_d  [NCH];
    logic            byp_q, byp_d;
    logic [W-1:0]    lpf_in_q, lpf_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;

    assign ch_nxt = ch_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        out_d    = out_q;
        byp_d    = byp_q;
        lpf_in_d = lpf_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;

        // A request that lands while a sequence is still running is dropped and flagged.
        if (frame_start && busy_q) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    for (int k = 0; k < NCH; k++) begin
                        snap_d[k] = ch_in[k*W +: W];
                    end
                    byp_d    = bypass;
                    lpf_in_d = ch_in[W-1:0];
                    busy_d   = 1'b1;
                    state_d  = RUN;
                    ch_d     = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (cnt_q < LAT) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    out_d[ch_q] = byp_q ? snap_q[ch_q] : lpf_out;
                    cnt_d       = '0;
                    if (ch_q < LAST) begin
                        ch_d     = ch_nxt;
                        lpf_in_d = snap_q[ch_nxt];
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            byp_q    <= 1'b0;
            lpf_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                snap_q[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            byp_q    <= byp_d;
            lpf_in_q <= lpf_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            snap_q   <= snap_d;
            out_q    <= out_d;
        end
    end

    for (genvar gk = 0; gk < NCH; gk++) begin : g_pack
        assign ch_out[gk*W +: W] = out_q[gk];
    end

    assign lpf_in  = lpf_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule
